uart_instruction_sender: RTL and testbench

- Serialises 15-bit instructions onto a UART TX line.
- Peer block to the instruction receiver: same frame format, same baud parameterisation, opposite direction.
- Frame: start bit, 15 data bits LSB-first, 1 or 2 stop bits.
- A one-entry holding register accepts the next instruction while the current frame is on the line, so back-to-back frames leave no idle gap.

---
 rtl/uart_instruction_sender.sv | 157 +++++++++++++++
 tb/tb_uart_instruction_sender.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_instruction_sender.sv
// ---------------------------------------------------------------------------
// uart_instruction_sender
//
// Serialises 15-bit instruction words onto a UART TX line. A frame is one
// start bit, 15 data bits LSB-first and STOP_BITS stop bits, each bit lasting
// CLKS_PER_BIT clock cycles. A one-entry holding register accepts the next
// word while a frame is on the line, so consecutive frames run with no idle
// gap between them.
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per UART bit period (>= 2)
//   STOP_BITS     number of stop bits (1 or 2)
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-high reset
//   instr_in     instruction word, sampled only on a handshake
//   instr_valid  instr_in holds a valid word
//   instr_ready  a word can be accepted (hold register empty)
//   tx           registered UART TX line, idles high
//   busy         high whenever a frame is in progress
//   frame_done   one-cycle pulse on the edge that ends the last stop bit
// ---------------------------------------------------------------------------
module uart_instruction_sender #(
   parameter int CLKS_PER_BIT = 434,
   parameter int STOP_BITS    = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [14:0] instr_in,
   input  logic        instr_valid,
   output logic        instr_ready,
   output logic        tx,
   output logic        busy,
   output logic        frame_done
);

   localparam int            CW        = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [3:0]    DATA_LAST = 4'd14;
   localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state;
   logic [CW-1:0] baud_cnt;
   logic [3:0]    bit_idx;
   logic [14:0]   shift_reg;
   logic [14:0]   hold_reg;
   logic          hold_full;

   logic accept;
   logic baud_end;
   logic frame_end;

   // A word is taken whenever the hold register is empty. frame_end marks the
   // edge that completes the final stop bit, where a waiting or freshly
   // accepted word starts its frame immediately.
   assign accept      = instr_valid && !hold_full;
   assign baud_end    = (baud_cnt == BAUD_LAST);
   assign frame_end   = (state == STOP) && baud_end && (bit_idx == STOP_LAST);
   assign instr_ready = !hold_full;
   assign busy        = (state != IDLE);

   // Transmit state machine. Words accepted while a frame is running park in
   // the hold register, except on the frame_end edge with the hold empty,
   // where the word bypasses the hold and goes straight into the shifter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         baud_cnt   <= '0;
         bit_idx    <= '0;
         shift_reg  <= '0;
         hold_reg   <= '0;
         hold_full  <= 1'b0;
         tx         <= 1'b1;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;

         if (accept && (state != IDLE) && !frame_end) begin
            hold_reg  <= instr_in;
            hold_full <= 1'b1;
         end

         case (state)
            IDLE: begin
               if (accept) begin
                  shift_reg <= instr_in;
                  tx        <= 1'b0;
                  baud_cnt  <= '0;
                  state     <= START;
               end else begin
                  tx <= 1'b1;
               end
            end

            START: begin
               if (baud_end) begin
                  baud_cnt <= '0;
                  tx       <= shift_reg[0];
                  bit_idx  <= '0;
                  state    <= DATA;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end

            DATA: begin
               if (baud_end) begin
                  baud_cnt <= '0;
                  if (bit_idx == DATA_LAST) begin
                     tx      <= 1'b1;
                     bit_idx <= '0;
                     state   <= STOP;
                  end else begin
                     shift_reg <= shift_reg >> 1;
                     tx        <= shift_reg[1];
                     bit_idx   <= bit_idx + 1'b1;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end

            STOP: begin
               if (baud_end) begin
                  baud_cnt <= '0;
                  if (bit_idx == STOP_LAST) begin
                     frame_done <= 1'b1;
                     bit_idx    <= '0;
                     if (hold_full) begin
                        shift_reg <= hold_reg;
                        hold_full <= 1'b0;
                        tx        <= 1'b0;
                        state     <= START;
                     end else if (accept) begin
                        shift_reg <= instr_in;
                        tx        <= 1'b0;
                        state     <= START;
                     end else begin
                        state <= IDLE;
                     end
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_instruction_sender.sv
// ---------------------------------------------------------------------------
// tb_uart_instruction_sender
//
// Drives two senders at CLKS_PER_BIT=4: unit A with one stop bit and unit B
// with two. A frame-position model (word + cycles elapsed since the start
// bit) predicts tx/busy/instr_ready/frame_done every cycle; a small UART
// decoder on unit A's line recovers words for order checks; directed
// scenarios add literal expectations before a randomized phase.
// ---------------------------------------------------------------------------
module tb_uart_instruction_sender;

   localparam int C     = 4;
   localparam int LEN_A = 17 * C;
   localparam int LEN_B = 18 * C;

   logic        clk;
   logic        reset;
   logic [14:0] a_in, b_in;
   logic        a_valid, b_valid;
   logic        a_ready, b_ready;
   logic        a_tx, b_tx;
   logic        a_busy, b_busy;
   logic        a_done, b_done;

   int n_checks = 0;
   int n_errors = 0;
   logic cmp_en = 1'b0;

   logic t2_bits [15] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0,
                          1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

   uart_instruction_sender #(.CLKS_PER_BIT(C), .STOP_BITS(1)) dut_a (
      .clk(clk), .reset(reset), .instr_in(a_in), .instr_valid(a_valid),
      .instr_ready(a_ready), .tx(a_tx), .busy(a_busy), .frame_done(a_done));

   uart_instruction_sender #(.CLKS_PER_BIT(C), .STOP_BITS(2)) dut_b (
      .clk(clk), .reset(reset), .instr_in(b_in), .instr_valid(b_valid),
      .instr_ready(b_ready), .tx(b_tx), .busy(b_busy), .frame_done(b_done));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: per unit, the word on the line, cycles since its start
   // bit began, and at most one waiting word.
   logic        m_active [2];
   int          m_elapsed[2];
   logic [14:0] m_word   [2];
   logic        m_pend   [2];
   logic [14:0] m_pend_w [2];
   logic        m_done   [2];

   task automatic modelStep(input int u, input logic v, input logic [14:0] w, input int len);
      logic acc;
      acc = v && !m_pend[u];
      m_done[u] = 1'b0;
      if (m_active[u]) begin
         m_elapsed[u]++;
         if (m_elapsed[u] == len) begin
            m_done[u] = 1'b1;
            if (m_pend[u]) begin
               m_word[u] = m_pend_w[u];
               m_pend[u] = 1'b0;
               m_elapsed[u] = 0;
            end else if (acc) begin
               m_word[u] = w;
               m_elapsed[u] = 0;
            end else begin
               m_active[u] = 1'b0;
            end
         end else if (acc) begin
            m_pend[u] = 1'b1;
            m_pend_w[u] = w;
         end
      end else if (acc) begin
         m_active[u] = 1'b1;
         m_word[u] = w;
         m_elapsed[u] = 0;
      end
   endtask

   function automatic logic model_tx(input int u);
      int b;
      if (!m_active[u]) return 1'b1;
      b = m_elapsed[u] / C;
      if (b == 0) return 1'b0;
      if (b <= 15) return m_word[u][b-1];
      return 1'b1;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int u = 0; u < 2; u++) begin
            m_active[u] = 1'b0;
            m_elapsed[u] = 0;
            m_word[u] = '0;
            m_pend[u] = 1'b0;
            m_pend_w[u] = '0;
            m_done[u] = 1'b0;
         end
      end else begin
         modelStep(0, a_valid, a_in, LEN_A);
         modelStep(1, b_valid, b_in, LEN_B);
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Every-cycle comparison of both units against the model.
   always @(negedge clk) begin
      if (cmp_en) begin
         checkOutput("a_tx",    32'(a_tx),    32'(model_tx(0)));
         checkOutput("a_busy",  32'(a_busy),  32'(m_active[0]));
         checkOutput("a_ready", 32'(a_ready), 32'(!m_pend[0]));
         checkOutput("a_done",  32'(a_done),  32'(m_done[0]));
         checkOutput("b_tx",    32'(b_tx),    32'(model_tx(1)));
         checkOutput("b_busy",  32'(b_busy),  32'(m_active[1]));
         checkOutput("b_ready", 32'(b_ready), 32'(!m_pend[1]));
         checkOutput("b_done",  32'(b_done),  32'(m_done[1]));
      end
   end

   // Independent UART decoder on unit A, sampling mid-bit.
   logic        rx_active;
   int          rx_k;
   logic [14:0] rx_word;
   logic [14:0] dec_q[$];

   always @(negedge clk or posedge reset) begin
      if (reset) begin
         rx_active = 1'b0;
         rx_k = 0;
      end else if (!rx_active) begin
         if (a_tx == 1'b0) begin
            rx_active = 1'b1;
            rx_k = 0;
            rx_word = '0;
         end
      end else begin
         rx_k++;
         if ((rx_k % C == C / 2) && (rx_k / C >= 1) && (rx_k / C <= 15))
            rx_word[rx_k / C - 1] = a_tx;
         if (rx_k == 16 * C + C / 2) begin
            dec_q.push_back(rx_word);
            rx_active = 1'b0;
         end
      end
   end

   task automatic applyStimulus(input int u, input logic [14:0] w, input logic v);
      @(negedge clk);
      if (u == 0) begin
         a_in = w;
         a_valid = v;
      end else begin
         b_in = w;
         b_valid = v;
      end
   endtask

   task automatic waitDone(input int u, input int budget, input string name);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if ((u == 0) ? a_done : b_done) return;
      end
      n_checks++;
      n_errors++;
      $display("[TB] FAIL %s: frame_done not seen within %0d cycles", name, budget);
   endtask

   task automatic checkResetOutputs(input string name);
      checkOutput({name, "_a_tx"},    32'(a_tx),    32'd1);
      checkOutput({name, "_a_busy"},  32'(a_busy),  32'd0);
      checkOutput({name, "_a_ready"}, 32'(a_ready), 32'd1);
      checkOutput({name, "_a_done"},  32'(a_done),  32'd0);
      checkOutput({name, "_b_tx"},    32'(b_tx),    32'd1);
      checkOutput({name, "_b_busy"},  32'(b_busy),  32'd0);
   endtask

   task automatic expectDecoded(input string name, input logic [14:0] w);
      if (dec_q.size() == 0) begin
         checkOutput({name, "_present"}, 32'd0, 32'd1);
      end else begin
         checkOutput(name, 32'(dec_q.pop_front()), 32'(w));
      end
   endtask

   initial begin
      logic exp_tx;
      reset = 1'b1;
      a_in = '0; b_in = '0; a_valid = 1'b0; b_valid = 1'b0;

      // Test 1: reset values, then reset asserted mid-frame
      repeat (3) @(negedge clk);
      checkResetOutputs("t1_por");
      reset = 1'b0;
      cmp_en = 1'b1;
      applyStimulus(0, 15'h1111, 1'b1);
      applyStimulus(0, 15'h0000, 1'b0);
      repeat (2) @(negedge clk);
      checkOutput("t1_tx_low_before_reset", 32'(a_tx), 32'd0);
      #2 reset = 1'b1;
      #1 checkResetOutputs("t1_async");
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checkResetOutputs("t1_hold");
      end
      reset = 1'b0;
      repeat (3) @(negedge clk);

      // Test 2: single frame 15'h5A3C
      dec_q.delete();
      applyStimulus(0, 15'h5A3C, 1'b1);
      applyStimulus(0, 15'h0000, 1'b0);
      for (int k = 0; k < 70; k++) begin
         if (k > 0) @(negedge clk);
         if (k < 4) exp_tx = 1'b0;
         else if (k < 64) exp_tx = t2_bits[(k - 4) / 4];
         else exp_tx = 1'b1;
         checkOutput("t2_tx",   32'(a_tx),   32'(exp_tx));
         checkOutput("t2_done", 32'(a_done), 32'(k == 68));
         checkOutput("t2_busy", 32'(a_busy), 32'(k < 68));
      end
      expectDecoded("t2_word", 15'h5A3C);

      // Test 3: back-to-back frames
      dec_q.delete();
      applyStimulus(0, 15'h7FFF, 1'b1);
      applyStimulus(0, 15'h0001, 1'b1);
      applyStimulus(0, 15'h0000, 1'b0);
      checkOutput("t3_ready_low", 32'(a_ready), 32'd0);
      waitDone(0, 100, "t3_first_done");
      checkOutput("t3_start2_tx", 32'(a_tx),    32'd0);
      checkOutput("t3_busy_kept", 32'(a_busy),  32'd1);
      checkOutput("t3_ready_ret", 32'(a_ready), 32'd1);
      waitDone(0, 100, "t3_second_done");
      @(negedge clk);
      checkOutput("t3_count", 32'(dec_q.size()), 32'd2);
      expectDecoded("t3_word0", 15'h7FFF);
      expectDecoded("t3_word1", 15'h0001);

      // Test 4: hold full with valid held high
      dec_q.delete();
      applyStimulus(0, 15'h2AAA, 1'b1);
      applyStimulus(0, 15'h5555, 1'b1);
      applyStimulus(0, 15'h1234, 1'b1);
      checkOutput("t4_ready_full", 32'(a_ready), 32'd0);
      waitDone(0, 100, "t4_first_done");
      checkOutput("t4_ready_drained", 32'(a_ready), 32'd1);
      @(negedge clk);
      checkOutput("t4_ready_taken", 32'(a_ready), 32'd0);
      a_valid = 1'b0;
      waitDone(0, 100, "t4_second_done");
      waitDone(0, 100, "t4_third_done");
      @(negedge clk);
      checkOutput("t4_count", 32'(dec_q.size()), 32'd3);
      expectDecoded("t4_word0", 15'h2AAA);
      expectDecoded("t4_word1", 15'h5555);
      expectDecoded("t4_word2", 15'h1234);

      // Test 5: reset during data bit 7 with a word held
      dec_q.delete();
      applyStimulus(0, 15'h3C5A, 1'b1);
      applyStimulus(0, 15'h6F0F, 1'b1);
      applyStimulus(0, 15'h0000, 1'b0);
      repeat (32) @(negedge clk);
      #2 reset = 1'b1;
      #1 checkResetOutputs("t5_async");
      repeat (3) @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 150; i++) begin
         @(negedge clk);
         checkOutput("t5_tx_idle", 32'(a_tx),   32'd1);
         checkOutput("t5_no_done", 32'(a_done), 32'd0);
      end
      checkOutput("t5_no_frames", 32'(dec_q.size()), 32'd0);

      // Test 6: two stop bits, all-zero word
      applyStimulus(1, 15'h0000, 1'b1);
      applyStimulus(1, 15'h0000, 1'b0);
      for (int k = 0; k < 76; k++) begin
         if (k > 0) @(negedge clk);
         checkOutput("t6_tx",   32'(b_tx),   32'(k >= 64));
         checkOutput("t6_done", 32'(b_done), 32'(k == 72));
         checkOutput("t6_busy", 32'(b_busy), 32'(k < 72));
      end

      // Randomized traffic on both units, with one asynchronous reset
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         a_valid = ($urandom_range(0, 3) == 0);
         a_in = 15'($urandom);
         b_valid = ($urandom_range(0, 3) == 0);
         b_in = 15'($urandom);
         if (i == 2000) begin
            #2 reset = 1'b1;
            #1 checkResetOutputs("rand_reset");
            @(negedge clk);
            reset = 1'b0;
         end
      end
      @(negedge clk);
      a_valid = 1'b0;
      b_valid = 1'b0;
      begin
         int waited;
         waited = 0;
         while ((a_busy || b_busy) && waited < 400) begin
            @(negedge clk);
            waited++;
         end
         checkOutput("final_idle", 32'(a_busy || b_busy), 32'd0);
      end
      repeat (3) @(negedge clk);
      cmp_en = 1'b0;

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
